rayid_freelist_ctrl: RTL and testbench
======================================

// Module: rayid_freelist_ctrl
// PURPOSE
//  Owns the pool of NUM_RAYS ray IDs shared by the shader front end (PRG -> sint/raystore path) and
//  the shader result path (pcalc/int/sint/ss returns). After reset or flush it sweeps every ID into a
//  free list. It then hands IDs out on an alloc port and takes them back on a free port.
//  A per-ID allocated bitmap detects double/illegal frees, and occupancy counters drive backpressure and debug.
// PARAMETERS
//  NUM_RAYS  512                 number of ray IDs in the pool (power of two)
//  ID_W      $clog2(NUM_RAYS)    width of a ray ID (9 at default, = $bits(rayID_t))
// PORTS
//  clk             in   1        single clock
//  rst             in   1        reset: asynchronous, active-low
//  flush           in   1        sync re-init request, single-cycle pulse
//  alloc_valid     out  1        free ID available on alloc_id
//  alloc_id        out  ID_W     ID offered to the requester (head of free list)
//  alloc_stall     in   1        requester cannot take the ID this cycle
//  free_valid      in   1        ID returned on free_id
//  free_id         in   ID_W     ID being released
//  free_stall      out  1        block cannot accept a free this cycle
//  init_done       out  1        pool initialised, block in RUN
//  num_free        out  ID_W+1   IDs currently in the free list
//  num_inflight    out  ID_W+1   IDs currently allocated
//  err_bad_free    out  1        sticky: a free named an ID not marked allocated
// BEHAVIOUR
//  Handshake rules
//  - valid/stall handshake on both ports. A transfer occurs when valid & ~stall.
//  - alloc_valid/alloc_id do not depend combinationally on alloc_stall.
//  Reset values (rst low)
//  - state=INIT, cnt=0, head=tail=0, bitmap all 0.
//  - Outputs: alloc_valid=0, alloc_id=0, free_stall=1, init_done=0, num_free=0, num_inflight=0, err_bad_free=0.
//  FSM: INIT, RUN.
//  - INIT: each cycle writes cnt to tail, then tail++, cnt++, num_free++.
//    - After writing NUM_RAYS-1, next state is RUN.
//    - In INIT: alloc_valid=0, free_stall=1.
//    - init_done rises exactly NUM_RAYS cycles after rst deasserts; num_free=NUM_RAYS at that point.
//  - RUN: alloc_valid = (num_free!=0) and free_stall=0.
//    - Alloc transfer: head++, num_free--, num_inflight++, bitmap[alloc_id]<=1.
//    - Free transfer, bitmap[free_id]==1: write free_id at tail, tail++, num_free++, num_inflight--, bitmap[free_id]<=0.
//    - Free transfer, bitmap[free_id]==0: ID dropped, no pointer or count change, err_bad_free<=1 (sticky until rst/flush).
//  - Simultaneous alloc+free in the same cycle both complete.
//    - num_free and num_inflight are unchanged in that case; head and tail each advance.
//    - The bitmap check uses the pre-cycle bitmap.
//    - No bypass: a freed ID is not visible at alloc_id before the cycle after it is written, even when num_free was 0.
//  - Pointers wrap modulo NUM_RAYS. Invariant in RUN: num_free+num_inflight==NUM_RAYS.
//  - Free list becomes empty: alloc_valid=0 next cycle, and frees are still accepted.
//  - Free list full: only reachable through an illegal free, which the bitmap rejects, so no overflow path exists.
//  - flush, any state: next cycle equals reset state. Any transfer in the flush cycle is discarded.
//  - rst asserted mid-INIT or mid-RUN: immediate async return to reset values.
//  Latency
//  - alloc_id is valid same cycle as alloc_valid: FWFT head read from a registered output.
//  - A freed ID becomes allocatable ≥1 cycle after its free transfer.
// STRUCTURE
//  - Shared package: rayID_t (existing), new enum freelist_state_e {FL_INIT, FL_RUN}.
//  - Sub-module rayid_ring: NUM_RAYS x ID_W circular buffer with FWFT registered head, wr/rd strobes, and head/tail pointers.
//    - Bitmap, FSM, init counter and occupancy counters live in the top.
//  - Async-reset flops use ff_ar with the reset polarity above.
// TESTING
//  1. Release rst, hold idle.
//     -> init_done=1 at cycle 512, num_free=512.
//     -> Allocs with alloc_stall=0 yield IDs 0,1,2,... in order.
//  2. Alloc 512 IDs back to back.
//     -> alloc_valid=0 the cycle after the 512th, num_inflight=512.
//     -> Free ID 7 -> alloc_valid=1 next cycle with alloc_id=7.
//  3. Hold alloc_stall=1 with alloc_valid=1.
//     -> alloc_id stays constant and num_free is unchanged.
//     -> Free ID 3 (allocated) in the same window -> num_free+1, and alloc_id is still the old head.
//  4. Same-cycle alloc and free of allocated ID 20.
//     -> num_free and num_inflight unchanged.
//     -> 20 reappears after all older free entries.
//  5. Free ID 100 twice, and separately free a never-allocated ID.
//     -> err_bad_free=1 after the second free of 100, and counts reflect one free only.
//     -> Error stays set until flush.
//  6. Pulse flush in RUN with 300 IDs inflight, and separately assert rst mid-INIT (cnt=200).
//     -> Reset values next cycle.
//     -> Full 512-cycle re-init, and allocs restart at ID 0.

Source files
------------

// File: rtl/rayid_freelist_ctrl_pkg.sv
// Shared types for the ray-ID free-list controller.
package rayid_freelist_ctrl_pkg;

  localparam int RAY_NUM  = 512;
  localparam int RAY_ID_W = $clog2(RAY_NUM);

  typedef logic [RAY_ID_W-1:0] rayID_t;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } freelist_state_e;

endpackage

// File: rtl/ff_ar.sv
// Plain register with asynchronous active-low clear to zero.
module ff_ar #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  // State register, cleared asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) q_o <= '0;
    else         q_o <= d_i;
  end

endmodule

// File: rtl/rayid_ring.sv
// Circular ID buffer with a registered first-word-fall-through head.
// Occupancy is tracked by the owner; the ring only moves pointers.
module rayid_ring #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 9,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_en;

  // Pointer and head-register next state; clear wins over any strobe
  always_comb begin
    wr_en  = wr_i && !clr_i;
    head_d = head_q + PTR_W'(rd_i);
    tail_d = tail_q + PTR_W'(wr_i);
    // A write landing on the slot the head will point at is forwarded into
    // the output register, so it shows up the cycle after the write.
    dout_d = (wr_i && (tail_q == head_d)) ? wdata_i : mem_q[head_d];
    if (clr_i) begin
      head_d = '0;
      tail_d = '0;
      dout_d = '0;
    end
  end

  // Storage array, no reset needed: contents are rebuilt by the init sweep
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[tail_q] <= wdata_i;
  end

  ff_ar #(.W(PTR_W))  u_head (.clk_i, .rst_ni, .d_i(head_d), .q_o(head_q));
  ff_ar #(.W(PTR_W))  u_tail (.clk_i, .rst_ni, .d_i(tail_d), .q_o(tail_q));
  ff_ar #(.W(DATA_W)) u_dout (.clk_i, .rst_ni, .d_i(dout_d), .q_o(dout_q));

  assign rdata_o = dout_q;

endmodule

// File: rtl/rayid_freelist_ctrl.sv
// Ray-ID pool: sweeps all IDs into a free list, then serves alloc/free
// with an allocated-bitmap guarding against double or stray frees.
module rayid_freelist_ctrl
  import rayid_freelist_ctrl_pkg::*;
#(
  parameter int NUM_RAYS = RAY_NUM,
  parameter int ID_W     = $clog2(NUM_RAYS)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  output logic            alloc_valid_o,
  output logic [ID_W-1:0] alloc_id_o,
  input  logic            alloc_stall_i,
  input  logic            free_valid_i,
  input  logic [ID_W-1:0] free_id_i,
  output logic            free_stall_o,
  output logic            init_done_o,
  output logic [ID_W:0]   num_free_o,
  output logic [ID_W:0]   num_inflight_o,
  output logic            err_bad_free_o
);

  freelist_state_e       state_q, state_d;
  logic                  state_raw_q;
  logic [ID_W-1:0]       cnt_q, cnt_d;
  logic [ID_W:0]         nfree_q, nfree_d, ninfl_q, ninfl_d;
  logic [NUM_RAYS-1:0]   bmap_q, bmap_d;
  logic                  err_q, err_d;

  logic                  run, alloc_vld, alloc_xfer, free_xfer, free_ok;
  logic                  ring_wr;
  logic [ID_W-1:0]       ring_wdata, head_id;

  assign state_q = freelist_state_e'(state_raw_q);

  // Handshake decode; alloc_valid depends only on registered state
  always_comb begin
    run        = (state_q == FL_RUN);
    alloc_vld  = run && (nfree_q != '0);
    alloc_xfer = alloc_vld && !alloc_stall_i;
    free_xfer  = run && free_valid_i;
    free_ok    = free_xfer && bmap_q[free_id_i];
    ring_wr    = !run || free_ok;
    ring_wdata = run ? free_id_i : cnt_q;
  end

  // FSM next state plus counters, bitmap and sticky error
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nfree_d = nfree_q;
    ninfl_d = ninfl_q;
    bmap_d  = bmap_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = FL_INIT;
      cnt_d   = '0;
      nfree_d = '0;
      ninfl_d = '0;
      bmap_d  = '0;
      err_d   = 1'b0;
    end else if (!run) begin
      cnt_d   = cnt_q + ID_W'(1);
      nfree_d = nfree_q + (ID_W+1)'(1);
      if (cnt_q == ID_W'(NUM_RAYS-1)) state_d = FL_RUN;
    end else begin
      // Check uses the pre-cycle bitmap; alloc and free never name the same live ID
      if (alloc_xfer)                      bmap_d[head_id]   = 1'b1;
      if (free_ok)                         bmap_d[free_id_i] = 1'b0;
      if (free_xfer && !bmap_q[free_id_i]) err_d             = 1'b1;
      nfree_d = nfree_q + (ID_W+1)'(free_ok) - (ID_W+1)'(alloc_xfer);
      ninfl_d = ninfl_q + (ID_W+1)'(alloc_xfer) - (ID_W+1)'(free_ok);
    end
  end

  ff_ar #(.W(1))        u_state (.clk_i, .rst_ni, .d_i(state_d), .q_o(state_raw_q));
  ff_ar #(.W(ID_W))     u_cnt   (.clk_i, .rst_ni, .d_i(cnt_d),   .q_o(cnt_q));
  ff_ar #(.W(ID_W+1))   u_nfree (.clk_i, .rst_ni, .d_i(nfree_d), .q_o(nfree_q));
  ff_ar #(.W(ID_W+1))   u_ninfl (.clk_i, .rst_ni, .d_i(ninfl_d), .q_o(ninfl_q));
  ff_ar #(.W(NUM_RAYS)) u_bmap  (.clk_i, .rst_ni, .d_i(bmap_d),  .q_o(bmap_q));
  ff_ar #(.W(1))        u_err   (.clk_i, .rst_ni, .d_i(err_d),   .q_o(err_q));

  rayid_ring #(.DEPTH(NUM_RAYS), .DATA_W(ID_W)) u_ring (
    .clk_i,
    .rst_ni,
    .clr_i   (flush_i),
    .wr_i    (ring_wr),
    .wdata_i (ring_wdata),
    .rd_i    (alloc_xfer),
    .rdata_o (head_id)
  );

  assign alloc_valid_o  = alloc_vld;
  assign alloc_id_o     = head_id;
  assign free_stall_o   = !run;
  assign init_done_o    = run;
  assign num_free_o     = nfree_q;
  assign num_inflight_o = ninfl_q;
  assign err_bad_free_o = err_q;

endmodule

// File: tb/tb_rayid_freelist_ctrl.sv
// Directed bench for the ray-ID free-list controller.
module tb_rayid_freelist_ctrl;

  localparam int N = 512;
  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst_n, flush, alloc_stall, free_valid;
  logic [W-1:0] free_id;
  logic         alloc_valid, free_stall, init_done, err_bad_free;
  logic [W-1:0] alloc_id;
  logic [W:0]   num_free, num_inflight;

  int n_assert = 0;
  int n_fail   = 0;

  rayid_freelist_ctrl #(.NUM_RAYS(N), .ID_W(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .flush_i        (flush),
    .alloc_valid_o  (alloc_valid),
    .alloc_id_o     (alloc_id),
    .alloc_stall_i  (alloc_stall),
    .free_valid_i   (free_valid),
    .free_id_i      (free_id),
    .free_stall_o   (free_stall),
    .init_done_o    (init_done),
    .num_free_o     (num_free),
    .num_inflight_o (num_inflight),
    .err_bad_free_o (err_bad_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".alloc_valid"}, 32'(alloc_valid), 0);
    chk({tag, ".alloc_id"}, 32'(alloc_id), 0);
    chk({tag, ".free_stall"}, 32'(free_stall), 1);
    chk({tag, ".init_done"}, 32'(init_done), 0);
    chk({tag, ".num_free"}, 32'(num_free), 0);
    chk({tag, ".num_inflight"}, 32'(num_inflight), 0);
    chk({tag, ".err"}, 32'(err_bad_free), 0);
  endtask

  // Runs a full init sweep, checking init_done rises on exactly the 512th edge
  task automatic chk_init(input string tag);
    for (int i = 0; i < N-1; i++) step();
    chk({tag, ".pre_done"}, 32'(init_done), 0);
    chk({tag, ".pre_nfree"}, 32'(num_free), N-1);
    chk({tag, ".pre_avalid"}, 32'(alloc_valid), 0);
    step();
    chk({tag, ".done"}, 32'(init_done), 1);
    chk({tag, ".nfree"}, 32'(num_free), N);
    chk({tag, ".free_stall"}, 32'(free_stall), 0);
    chk({tag, ".avalid"}, 32'(alloc_valid), 1);
    chk({tag, ".aid"}, 32'(alloc_id), 0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; alloc_stall = 1'b1; free_valid = 1'b0; free_id = '0;
    step(); step();
    chk_reset("rst");

    // 1: release reset, idle through init
    rst_n = 1'b1;
    chk_init("init1");

    // 1/2: drain the whole pool in order
    alloc_stall = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("drain.aid", {31'(alloc_valid), 1'b0} | 32'(alloc_id != W'(i)), 32'h2);
      step();
    end
    chk("empty.avalid", 32'(alloc_valid), 0);
    chk("empty.ninfl", 32'(num_inflight), N);
    chk("empty.nfree", 32'(num_free), 0);
    chk("empty.free_stall", 32'(free_stall), 0);

    // 2: free 7 into an empty list
    free_valid = 1'b1; free_id = W'(7);
    step();
    chk("free7.avalid", 32'(alloc_valid), 1);
    chk("free7.aid", 32'(alloc_id), 7);
    chk("free7.nfree", 32'(num_free), 1);

    // 3: stalled head while freeing 3
    alloc_stall = 1'b1; free_id = W'(3);
    step();
    chk("stall.aid", 32'(alloc_id), 7);
    chk("stall.nfree", 32'(num_free), 2);
    chk("stall.ninfl", 32'(num_inflight), N-2);
    free_valid = 1'b0;
    step(); step();
    chk("stall2.aid", 32'(alloc_id), 7);
    chk("stall2.nfree", 32'(num_free), 2);

    // 4: simultaneous alloc of 7 and free of 20
    alloc_stall = 1'b0; free_valid = 1'b1; free_id = W'(20);
    step();
    chk("both.nfree", 32'(num_free), 2);
    chk("both.ninfl", 32'(num_inflight), N-2);
    chk("both.aid", 32'(alloc_id), 3);
    free_valid = 1'b0;
    step();
    chk("order.aid", 32'(alloc_id), 20);
    step();
    chk("order.avalid", 32'(alloc_valid), 0);
    chk("order.ninfl", 32'(num_inflight), N);
    alloc_stall = 1'b1;

    // 5: double free of 100
    free_valid = 1'b1; free_id = W'(100);
    step();
    chk("f100.nfree", 32'(num_free), 1);
    chk("f100.err", 32'(err_bad_free), 0);
    step();
    chk("f100b.err", 32'(err_bad_free), 1);
    chk("f100b.nfree", 32'(num_free), 1);
    chk("f100b.ninfl", 32'(num_inflight), N-1);
    chk("f100b.aid", 32'(alloc_id), 100);
    free_valid = 1'b0;
    step(); step(); step();
    chk("sticky.err", 32'(err_bad_free), 1);

    // 6: flush with transfers in the same cycle (both discarded)
    flush = 1'b1; alloc_stall = 1'b0; free_valid = 1'b1; free_id = W'(50);
    step();
    flush = 1'b0; alloc_stall = 1'b1; free_valid = 1'b0;
    chk_reset("flush1");
    chk_init("init2");

    // 5: free of a never-allocated ID
    free_valid = 1'b1; free_id = W'(5);
    step();
    free_valid = 1'b0;
    chk("stray.err", 32'(err_bad_free), 1);
    chk("stray.nfree", 32'(num_free), N);
    chk("stray.ninfl", 32'(num_inflight), 0);

    // 6: 300 inflight, then flush
    alloc_stall = 1'b0;
    for (int i = 0; i < 300; i++) begin
      chk("a300.aid", 32'(alloc_id), i);
      step();
    end
    alloc_stall = 1'b1;
    chk("a300.ninfl", 32'(num_inflight), 300);
    chk("a300.nfree", 32'(num_free), N-300);
    chk("a300.aid_next", 32'(alloc_id), 300);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_reset("flush2");

    // 6: async reset mid-init at cnt=200
    for (int i = 0; i < 200; i++) step();
    chk("mid.nfree", 32'(num_free), 200);
    chk("mid.done", 32'(init_done), 0);
    rst_n = 1'b0;
    #2;
    chk_reset("async");
    step();
    rst_n = 1'b1;
    chk_init("init3");
    alloc_stall = 1'b0;
    step();
    alloc_stall = 1'b1;
    chk("restart.aid", 32'(alloc_id), 1);
    chk("restart.ninfl", 32'(num_inflight), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
